// File: rtl/core_ex_lsu_bus.sv
// core_ex_lsu_bus: EX-stage load/store unit on a valid/ready memory bus.
// Define CORE_LSU_TIMEOUT_EN to bound the REQ/RSP wait to TIMEOUT cycles.
module core_ex_lsu_bus #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_i_valid,
  output logic              lsu_i_ready,
  input  logic              lsu_i_load,
  input  logic              lsu_i_store,
  input  logic [1:0]        lsu_i_size,
  input  logic              lsu_i_unsigned,
  input  logic [XLEN-1:0]   lsu_i_addr,
  input  logic [XLEN-1:0]   lsu_i_wdata,
  output logic              lsu_o_valid,
  input  logic              lsu_o_ready,
  output logic [XLEN-1:0]   lsu_o_rdata,
  output logic              lsu_o_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err
);
  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned LW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic            ld_q, ld_d;
  logic            st_q, st_d;
  logic            uns_q, uns_d;
  logic            err_q, err_d;
  logic [1:0]      size_q, size_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] res_q, res_d;

  logic [LW-1:0]   lane;
  logic            bad_i;
  logic            op_i;
  logic            tmo;
  logic [7:0]      ones;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ext_mask;
  logic            sign;
  logic [XLEN-1:0] load_val;

  assign lane = addr_q[LW-1:0];
  assign op_i = lsu_i_load | lsu_i_store;

  // Alignment and size legality of the presented instruction
  always_comb begin
    bad_i = 1'b0;
    unique case (lsu_i_size)
      2'd0:    bad_i = 1'b0;
      2'd1:    bad_i = lsu_i_addr[0];
      2'd2:    bad_i = |lsu_i_addr[1:0];
      default: bad_i = (XLEN != 64) || (|lsu_i_addr[2:0]);
    endcase
  end

  always_comb begin
    ones = 8'hFF;
    unique case (size_q)
      2'd0:    ones = 8'h01;
      2'd1:    ones = 8'h03;
      2'd2:    ones = 8'h0F;
      default: ones = 8'hFF;
    endcase
  end

  // Load alignment: shift lane down, truncate to size, extend
  always_comb begin
    sh       = mem_rsp_rdata >> {lane, 3'b000};
    ext_mask = '1;
    sign     = sh[XLEN-1];
    unique case (size_q)
      2'd0: begin
        ext_mask = XLEN'(8'hFF);
        sign     = sh[7];
      end
      2'd1: begin
        ext_mask = XLEN'(16'hFFFF);
        sign     = sh[15];
      end
      2'd2: begin
        ext_mask = XLEN'(32'hFFFF_FFFF);
        sign     = sh[31];
      end
      default: ;
    endcase
    load_val = sh & ext_mask;
    if (sign && !uns_q) begin
      load_val = load_val | ~ext_mask;
    end
  end

  assign lsu_i_ready   = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_rsp_ready = (state_q == RSP);
  assign lsu_o_valid   = (state_q == DONE);

  assign mem_req_addr  = mem_req_valid ?
                         {addr_q[XLEN-1:LW], {LW{1'b0}}} : '0;
  assign mem_req_wen   = mem_req_valid & st_q;
  assign mem_req_wdata = mem_req_valid ?
                         (wdata_q << {lane, 3'b000}) : '0;
  assign mem_req_wmask = mem_req_wen ?
                         (NB'(ones) << lane) : '0;

  assign lsu_o_rdata   = lsu_o_valid ? res_q : '0;
  assign lsu_o_err     = lsu_o_valid & err_q;

`ifdef CORE_LSU_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (state_q == REQ || state_q == RSP) ?
                 cnt_q + 16'd1 : '0;
  assign tmo   = (cnt_q >= 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    st_d    = st_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_i_valid) begin
          ld_d    = lsu_i_load;
          st_d    = lsu_i_store;
          uns_d   = lsu_i_unsigned;
          size_d  = lsu_i_size;
          addr_d  = lsu_i_addr;
          wdata_d = lsu_i_wdata;
          res_d   = '0;
          err_d   = op_i & bad_i;
          state_d = (op_i && !bad_i) ? REQ : DONE;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RSP;
        end else if (tmo) begin
          state_d = DONE;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      RSP: begin
        // A response in the limit cycle takes priority over timeout
        if (mem_rsp_valid) begin
          state_d = DONE;
          res_d   = ld_q ? load_val : '0;
          err_d   = mem_rsp_err;
        end else if (tmo) begin
          state_d = DONE;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        if (lsu_o_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_core_ex_lsu_bus.sv
// tb_core_ex_lsu_bus: vector table, hand sequences and random
// transactions against a reference model of the LSU.
module tb_core_ex_lsu_bus;
  localparam int XLEN = 32;
  localparam int TMO  = 10;

  logic        clk;
  logic        rst_n;
  logic        lsu_i_valid;
  logic        lsu_i_ready;
  logic        lsu_i_load;
  logic        lsu_i_store;
  logic [1:0]  lsu_i_size;
  logic        lsu_i_unsigned;
  logic [31:0] lsu_i_addr;
  logic [31:0] lsu_i_wdata;
  logic        lsu_o_valid;
  logic        lsu_o_ready;
  logic [31:0] lsu_o_rdata;
  logic        lsu_o_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  int n_tests;
  int n_fail;

  core_ex_lsu_bus #(
    .XLEN(XLEN),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lsu_i_valid(lsu_i_valid),
    .lsu_i_ready(lsu_i_ready),
    .lsu_i_load(lsu_i_load),
    .lsu_i_store(lsu_i_store),
    .lsu_i_size(lsu_i_size),
    .lsu_i_unsigned(lsu_i_unsigned),
    .lsu_i_addr(lsu_i_addr),
    .lsu_i_wdata(lsu_i_wdata),
    .lsu_o_valid(lsu_o_valid),
    .lsu_o_ready(lsu_o_ready),
    .lsu_o_rdata(lsu_o_rdata),
    .lsu_o_err(lsu_o_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    logic        rerr;
    int          rs;
    int          rd;
    int          os;
    logic        x_req;
    logic [31:0] x_addr;
    logic        x_wen;
    logic [3:0]  x_mask;
    logic [31:0] x_wdata;
    int          x_lat;
    logic [31:0] x_rdata;
    logic        x_err;
  } vec_t;

  localparam int NT = 14;
  vec_t tbl[NT];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic idle_inputs();
    lsu_i_valid   = 1'b0;
    lsu_o_ready   = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference: derived from the access rules, not the FSM
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          nb;
    int          lane;
    logic [63:0] m;
    logic [63:0] val;
    bit          bad;
    r    = v;
    nb   = 1 << v.size;
    lane = int'(v.addr % 4);
    bad  = (v.size == 2'd3) || ((v.addr % nb) != 0);
    r.x_req   = (v.ld || v.st) && !bad;
    r.x_err   = (v.ld || v.st) && bad;
    r.x_lat   = 1;
    r.x_rdata = 0;
    r.x_addr  = 0;
    r.x_wen   = 0;
    r.x_mask  = 0;
    r.x_wdata = 0;
    if (r.x_req) begin
      r.x_addr  = v.addr - 32'(lane);
      r.x_wen   = v.st;
      r.x_mask  = v.st ? 4'(((1 << nb) - 1) << lane) : 4'd0;
      r.x_wdata = 32'(64'(v.wdata) << (8 * lane));
      r.x_lat   = 3 + v.rs + v.rd;
      r.x_err   = v.rerr;
      if (v.ld) begin
        m   = (64'd1 << (8 * nb)) - 64'd1;
        val = (64'(v.mword) >> (8 * lane)) & m;
        if (!v.uns && val[8*nb-1]) val = val | ~m;
        r.x_rdata = val[31:0];
      end
    end
    return r;
  endfunction

  task automatic run_vec(input vec_t v);
    int k, rc, pc, oc;
    bit done, bail, first_o, seen_req;
    lsu_i_valid    = 1'b1;
    lsu_i_load     = v.ld;
    lsu_i_store    = v.st;
    lsu_i_size     = v.size;
    lsu_i_unsigned = v.uns;
    lsu_i_addr     = v.addr;
    lsu_i_wdata    = v.wdata;
    chk("i_ready", 32'(lsu_i_ready), 1);
    @(negedge clk);
    k = 1; rc = 0; pc = 0; oc = 0;
    done = 0; bail = 0; first_o = 1; seen_req = 0;
    while (!done && k < 200) begin
      idle_inputs();
      mem_rsp_rdata = $urandom;
      if (mem_req_valid) begin
        if (!seen_req)
          chk("req_expected", 32'(mem_req_valid), 32'(v.x_req));
        seen_req = 1;
        if (!v.x_req) begin
          bail = 1;
          done = 1;
        end else begin
          chk("req_addr", mem_req_addr, v.x_addr);
          chk("req_wen", 32'(mem_req_wen), 32'(v.x_wen));
          chk("req_wmask", 32'(mem_req_wmask), 32'(v.x_mask));
          chk("req_wdata", mem_req_wdata, v.x_wdata);
          mem_req_ready = (rc >= v.rs);
          mem_rsp_valid = 1'b1;
          mem_rsp_err   = 1'b1;
          rc++;
        end
      end else if (mem_rsp_ready) begin
        mem_rsp_valid = (pc >= v.rd);
        if (mem_rsp_valid) begin
          mem_rsp_rdata = v.mword;
          mem_rsp_err   = v.rerr;
        end
        pc++;
      end else if (lsu_o_valid) begin
        if (first_o) begin
          chk("o_latency", 32'(k), 32'(v.x_lat));
          chk("i_ready_done", 32'(lsu_i_ready), 0);
          first_o = 0;
        end
        chk("o_rdata", lsu_o_rdata, v.x_rdata);
        chk("o_err", 32'(lsu_o_err), 32'(v.x_err));
        lsu_o_ready   = (oc >= v.os);
        done          = lsu_o_ready;
        oc++;
        lsu_i_valid   = 1'b1;
        lsu_i_load    = 1'b1;
        lsu_i_store   = 1'b0;
        lsu_i_size    = 2'd0;
        mem_rsp_valid = 1'b1;
      end else begin
        chk("busy_state", 32'(lsu_i_ready), 0);
        bail = 1;
        done = 1;
      end
      @(negedge clk);
      k++;
    end
    idle_inputs();
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL budget: no result after %0d cycles", k);
      bail = 1;
    end else if (!bail) begin
      chk("back_idle", 32'(lsu_i_ready), 1);
      chk("o_valid_low", 32'(lsu_o_valid), 0);
    end
    if (bail) do_reset();
  endtask

  initial begin
    int k;
    vec_t v;
    n_tests = 0;
    n_fail  = 0;
    // ld st sz uns addr wdata mword rerr rs rd os
    // x_req x_addr x_wen x_mask x_wdata x_lat x_rdata x_err
    tbl[0]  = '{0, 1, 2'd2, 0, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0,
                1, 32'h104, 1, 4'hF, 32'hDEADBEEF, 3, 32'h0, 0};
    tbl[1]  = '{1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, 0,
                1, 32'h100, 0, 4'h0, 32'h0, 3, 32'hFFFFFF80, 0};
    tbl[2]  = '{1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF0000, 0, 0, 0, 0,
                1, 32'h100, 0, 4'h0, 32'h0, 3, 32'h00000080, 0};
    tbl[3]  = '{0, 1, 2'd1, 0, 32'h101, 32'h1234, 32'h0, 0, 0, 0, 0,
                0, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0, 1};
    tbl[4]  = '{1, 0, 2'd2, 0, 32'h200, 32'h0, 32'h12345678, 0, 3, 2, 1,
                1, 32'h200, 0, 4'h0, 32'h0, 8, 32'h12345678, 0};
    tbl[5]  = '{0, 0, 2'd2, 0, 32'h55, 32'hFFFF, 32'h0, 0, 0, 0, 0,
                0, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0, 0};
    tbl[6]  = '{1, 0, 2'd1, 0, 32'h102, 32'h0, 32'hBEEF1234, 0, 0, 0, 0,
                1, 32'h100, 0, 4'h0, 32'h0, 3, 32'hFFFFBEEF, 0};
    tbl[7]  = '{0, 1, 2'd1, 0, 32'h106, 32'h0000ABCD, 32'h0, 0, 0, 0, 0,
                1, 32'h104, 1, 4'hC, 32'hABCD0000, 3, 32'h0, 0};
    tbl[8]  = '{1, 0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0,
                0, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0, 1};
    tbl[9]  = '{0, 1, 2'd0, 0, 32'h101, 32'h5A, 32'h0, 0, 0, 0, 0,
                1, 32'h100, 1, 4'h2, 32'h5A00, 3, 32'h0, 0};
    tbl[10] = '{0, 1, 2'd2, 0, 32'h300, 32'hCAFEF00D, 32'h11111111, 1,
                1, 1, 0,
                1, 32'h300, 1, 4'hF, 32'hCAFEF00D, 5, 32'h0, 1};
    tbl[11] = '{1, 0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 0, 0, 0, 0,
                0, 32'h0, 0, 4'h0, 32'h0, 1, 32'h0, 1};
    tbl[12] = '{1, 0, 2'd0, 1, 32'h101, 32'h0, 32'h0000A500, 0, 0, 2, 2,
                1, 32'h100, 0, 4'h0, 32'h0, 5, 32'h000000A5, 0};
    tbl[13] = '{1, 0, 2'd1, 0, 32'h100, 32'h0, 32'h77778001, 0, 0, 0, 0,
                1, 32'h100, 0, 4'h0, 32'h0, 3, 32'hFFFF8001, 0};

    idle_inputs();
    lsu_i_load     = 1'b1;
    lsu_i_store    = 1'b1;
    lsu_i_size     = 2'd2;
    lsu_i_unsigned = 1'b0;
    lsu_i_addr     = 32'hFFFF_FFFF;
    lsu_i_wdata    = 32'hFFFF_FFFF;
    mem_rsp_rdata  = 32'hFFFF_FFFF;
    rst_n          = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_i_ready", 32'(lsu_i_ready), 1);
    chk("rst_o_valid", 32'(lsu_o_valid), 0);
    chk("rst_o_err", 32'(lsu_o_err), 0);
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_rsp_ready", 32'(mem_rsp_ready), 0);
    chk("rst_wen", 32'(mem_req_wen), 0);
    chk("rst_o_rdata", lsu_o_rdata, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wdata", mem_req_wdata, 0);
    chk("rst_req_wmask", 32'(mem_req_wmask), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_i_ready", 32'(lsu_i_ready), 1);
    chk("post_rst_o_valid", 32'(lsu_o_valid), 0);

    for (int i = 0; i < NT; i++) run_vec(tbl[i]);

    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_err   = 1'b1;
      mem_rsp_rdata = $urandom;
      @(negedge clk);
      chk("stray_rsp_ready", 32'(mem_rsp_ready), 0);
      chk("stray_o_valid", 32'(lsu_o_valid), 0);
    end
    idle_inputs();

    lsu_i_valid = 1'b1;
    lsu_i_load  = 1'b1;
    lsu_i_store = 1'b0;
    lsu_i_size  = 2'd2;
    lsu_i_addr  = 32'h500;
    @(negedge clk);
    lsu_i_valid   = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("rrsp_in_rsp", 32'(mem_rsp_ready), 1);
    rst_n = 1'b0;
    #1;
    chk("rrsp_i_ready", 32'(lsu_i_ready), 1);
    chk("rrsp_req_valid", 32'(mem_req_valid), 0);
    chk("rrsp_rsp_ready", 32'(mem_rsp_ready), 0);
    chk("rrsp_o_valid", 32'(lsu_o_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rrsp_after_i_ready", 32'(lsu_i_ready), 1);
    chk("rrsp_after_o_valid", 32'(lsu_o_valid), 0);

`ifdef CORE_LSU_TIMEOUT_EN
    lsu_i_valid = 1'b1;
    lsu_i_load  = 1'b1;
    lsu_i_store = 1'b0;
    lsu_i_size  = 2'd2;
    lsu_i_addr  = 32'h400;
    @(negedge clk);
    lsu_i_valid   = 1'b0;
    mem_req_ready = 1'b1;
    k = 1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    k = 2;
    while (!lsu_o_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("tmo_latency", 32'(k), 32'(TMO + 1));
    chk("tmo_err", 32'(lsu_o_err), 1);
    chk("tmo_rdata", lsu_o_rdata, 0);
    lsu_o_ready = 1'b1;
    @(negedge clk);
    lsu_o_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = $urandom;
      @(negedge clk);
      chk("tmo_stray_rsp_ready", 32'(mem_rsp_ready), 0);
      chk("tmo_stray_o_valid", 32'(lsu_o_valid), 0);
      chk("tmo_stray_i_ready", 32'(lsu_i_ready), 1);
    end
    idle_inputs();
`endif

    for (int i = 0; i < 80; i++) begin
      int op;
      v       = tbl[0];
      op      = int'($urandom_range(0, 5));
      v.ld    = (op >= 1 && op <= 3);
      v.st    = (op >= 4);
      v.size  = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) v.size = 2'd3;
      v.uns   = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
      v.wdata = $urandom;
      v.mword = $urandom;
      v.rerr  = ($urandom_range(0, 9) == 0);
      v.rs    = int'($urandom_range(0, 3));
      v.rd    = int'($urandom_range(0, 3));
      v.os    = int'($urandom_range(0, 2));
      run_vec(model(v));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
